// File: rtl/pipe_reg_if.sv
// Valid/ready handshake bundle for pipe_reg: upstream (in_*) and downstream (out_*) sides.
// master = the environment driving the pipe, slave = the pipe itself.
interface pipe_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_reg.sv
// Elastic pipeline register: STAGES stages of WIDTH bits with valid/ready handshake, flush and
// occupancy count. Define PIPE_REG_DATA_CLEAR_EN to also clear data registers on reset/flush.
module pipe_reg #(
    parameter int  WIDTH  = 32,
    parameter int  STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    pipe_reg_if.slave     bus,
    output logic [CW-1:0] count
);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_reg: STAGES must be at least 1");
    end

    logic [WIDTH-1:0]  data [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic              xfer_in;
    logic              xfer_out;

    // A stage is ready if it, or any stage downstream of it, is empty, or the sink accepts.
    always_comb begin
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = r || !v[k];
            rdy[k] = r;
        end
    end

    assign bus.in_ready  = rdy[0] && !flush;
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = data[STAGES-1];
    assign xfer_in       = bus.in_valid && bus.in_ready;
    assign xfer_out      = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v     <= '0;
            count <= '0;
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            if (rdy[0]) v[0] <= xfer_in;
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) v[k] <= v[k-1];
            end
            case ({xfer_in, xfer_out})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_REG_DATA_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) data[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) data[k] <= '0;
        end else begin
            if (xfer_in) data[0] <= bus.in_data;
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k] && v[k-1]) data[k] <= data[k-1];
            end
        end
    end
`else
    // No reset on the datapath; contents of empty stages are don't-care.
    always_ff @(posedge clk) begin
        if (xfer_in) data[0] <= bus.in_data;
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k] && v[k-1]) data[k] <= data[k-1];
        end
    end
`endif

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of STAGES WIDTH-bit registers, each with a valid bit, joined by a valid/ready handshake so that upstream stalls only when the whole chain is full and downstream is not accepting. It is the general successor to the single-bit D flip-flop and is used between datapath stages (register-file read, ALU, memory) wherever a configurable-depth, stallable, flushable delay line is needed.

## Interface
- WIDTH, 32, data bits per stage (>=1)
- STAGES, 2, number of register stages (>=1; 0 is illegal and must fail elaboration)
- CW, $clog2(STAGES+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears state immediately, independent of clk
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  pipe accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  last stage holds a word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  last-stage word
- count  out  CW  number of stages currently holding valid words

## Operation
- Stage k (0 = input side, STAGES-1 = output side) holds data[k], v[k].
- Stage ready: rdy[STAGES-1] = !v[STAGES-1] || out_ready; rdy[k] = !v[k] || rdy[k+1]. Ready chain is combinational from out_ready to in_ready.
- in_ready = rdy[0] && !flush.
- On posedge with rdy[k]: stage 0 loads in_data, v[0] <= in_valid && in_ready; stage k>0 loads data[k-1], v[k] <= v[k-1]. Stages with !rdy[k] hold data and valid.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- out_valid = v[STAGES-1]; out_data = data[STAGES-1].
- count: registered; +1 on transfer-in only, -1 on transfer-out only, unchanged on both or neither; always equals popcount of v[].
- flush (priority over everything except reset): at next posedge all v[] <= 0, count <= 0; input offered that cycle is not accepted (in_ready = 0); out_valid/out_data during the flush cycle remain visible but a coincident out_ready handshake still counts as delivered to downstream.
- Data registers only load when their stage is ready; no data movement into an empty stage unless its predecessor is valid (data content of invalid stages is don't-care unless the macro below is set).

## Timing
- Reset (async assert): v[] = 0, count = 0, out_valid = 0, in_ready = 1 (when flush=0). out_data per Configuration.
- Reset deassert: first posedge after deassert is a normal cycle.
- Latency: word accepted at edge N appears on out_valid after edge N+STAGES-1 (visible in cycle following edge N+STAGES-1) with out_ready held 1.
- Throughput: 1 word/cycle with out_ready=1, including when full (simultaneous in/out on a full pipe is legal).
- Full (count=STAGES) and out_ready=0: in_ready=0, all stages hold.
- Bubbles collapse: a stalled output lets upstream stages advance into empty stages.
- Reset mid-transfer: all in-flight words discarded; no output transfer reported in that cycle.

## Configuration
- PIPE_REG_DATA_CLEAR_EN defined: data[] also cleared to 0 on reset and on flush; out_data = 0 whenever pipe is empty after reset/flush.
- Undefined (default): only valid bits and count are reset/flushed; data registers have no reset (smaller, faster), out_data undefined until first word reaches output.

## Test plan
- Reset: assert reset asynchronously mid-cycle with 2 words in flight -> out_valid=0, count=0 immediately; in_ready=1; with macro, out_data=0.
- Streaming, WIDTH=32, STAGES=3: inputs 0x1,0x2,0x3,0x4 back-to-back, out_ready=1 -> outputs 0x1..0x4 in order, first after 3 edges, one per cycle, count steady at 3.
- Back-pressure: fill with 0xA,0xB (STAGES=2), out_ready=0 -> in_ready=0, count=2, out_data=0xA held; raise out_ready with new in 0xC -> 0xA out and 0xC in same edge, count stays 2.
- Bubble collapse: STAGES=4, one word 0x55 in, out_ready=0 -> word reaches last stage after 3 edges; second word 0x66 advances to stage 2, count=2.
- Flush: pipe holding 3 words, flush=1 with in_valid=1 -> in_ready=0, next edge count=0, out_valid=0, offered word not delivered later.
- STAGES=1 edge case: simultaneous accept/deliver every cycle with out_ready=1 -> full throughput, count toggles never beyond 1.
